// File: rtl/instr_fetch_unit.sv
// Instruction fetch sequencer: owns the PC, runs the imem req/ack handshake,
// presents one instruction at a time and computes seq/branch/jump targets.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_FLUSH | one idle cycle after reset, imem_req low, ack ignored
// S_FETCH | imem_req high at pc, waiting for ack, timeout counting
// S_ISSUE | instr valid for decode, held while stalled
// S_ERR   | fetch timed out, sticky until reset
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16
) (
  input  logic        i_clk,
  input  logic        i_reset,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_rdata,
  input  logic [1:0]  i_pcsrc,
  input  logic        i_stall,
  output logic [31:0] o_instr,
  output logic [5:0]  o_opcode,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc_plus4,
  output logic        o_instr_valid,
  output logic        o_fetch_err
);

  typedef enum logic [1:0] {S_FLUSH, S_FETCH, S_ISSUE, S_ERR} state_t;

  // Last no-ack cycle count before declaring a timeout.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic [31:0] r_instr, w_instr_nxt;
  logic [7:0]  r_cnt, w_cnt_nxt;
  logic        r_err, w_err_nxt;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_br_target;
  logic [31:0] w_jmp_target;
  logic        w_ack_take;

  assign w_pc_plus4   = r_pc + 32'd4;
  assign w_br_target  = w_pc_plus4 + {{14{r_instr[15]}}, r_instr[15:0], 2'b00};
  assign w_jmp_target = {w_pc_plus4[31:28], r_instr[25:0], 2'b00};

  assign o_imem_req    = (r_state == S_FETCH);
  assign o_instr_valid = (r_state == S_ISSUE);
  assign o_imem_addr   = r_pc;
  assign o_pc          = r_pc;
  assign o_pc_plus4    = w_pc_plus4;
  assign o_instr       = r_instr;
  assign o_opcode      = r_instr[31:26];
  assign o_fetch_err   = r_err;

  // Data is only accepted while a request is actually outstanding.
  assign w_ack_take = o_imem_req && i_imem_ack;

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state <= S_FLUSH;
      r_pc    <= RESET_PC;
      r_instr <= 32'h0;
      r_cnt   <= 8'h0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_instr <= w_instr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // Next-state, PC selection, capture and timeout logic.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_instr_nxt = r_instr;
    w_cnt_nxt   = r_cnt;
    w_err_nxt   = r_err;
    case (r_state)
      S_FLUSH: begin
        w_cnt_nxt   = 8'h0;
        w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        if (w_ack_take) begin
          w_instr_nxt = i_imem_rdata;
          w_cnt_nxt   = 8'h0;
          w_state_nxt = S_ISSUE;
        end else if (r_cnt >= TIMEOUT_LAST) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = S_ERR;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      S_ISSUE: begin
        w_cnt_nxt = 8'h0;
        if (!i_stall) begin
          case (i_pcsrc)
            2'b01:   w_pc_nxt = w_br_target;
            2'b10:   w_pc_nxt = w_jmp_target;
            default: w_pc_nxt = w_pc_plus4;
          endcase
          w_state_nxt = S_FETCH;
        end
      end
      S_ERR: begin
        w_err_nxt = 1'b1;
      end
      default: begin
        w_state_nxt = S_FLUSH;
      end
    endcase
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit. Two instances share all inputs: a low
// one (RESET_PC=0x100) and a high one just below the 0x3000_0000 region so
// jump targets that take their top nibble from pc+4 can be exercised.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        ack;
  logic [31:0] rdata;
  logic [1:0]  pcsrc;
  logic        stall;

  logic        a_req, a_valid, a_err;
  logic [31:0] a_addr, a_instr, a_pc, a_pc4;
  logic [5:0]  a_op;
  logic        b_req, b_valid, b_err;
  logic [31:0] b_addr, b_instr, b_pc, b_pc4;
  logic [5:0]  b_op;

  int n_checks = 0;
  int n_errors = 0;

  instr_fetch_unit #(.RESET_PC(32'h0000_0100), .TIMEOUT(16)) u_dut (
    .i_clk(clk), .i_reset(rst_n),
    .o_imem_req(a_req), .o_imem_addr(a_addr),
    .i_imem_ack(ack), .i_imem_rdata(rdata),
    .i_pcsrc(pcsrc), .i_stall(stall),
    .o_instr(a_instr), .o_opcode(a_op), .o_pc(a_pc), .o_pc_plus4(a_pc4),
    .o_instr_valid(a_valid), .o_fetch_err(a_err)
  );

  instr_fetch_unit #(.RESET_PC(32'h2FFF_FFFC), .TIMEOUT(16)) u_dut_hi (
    .i_clk(clk), .i_reset(rst_n),
    .o_imem_req(b_req), .o_imem_addr(b_addr),
    .i_imem_ack(ack), .i_imem_rdata(rdata),
    .i_pcsrc(pcsrc), .i_stall(stall),
    .o_instr(b_instr), .o_opcode(b_op), .o_pc(b_pc), .o_pc_plus4(b_pc4),
    .o_instr_valid(b_valid), .o_fetch_err(b_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  // Reset both instances and leave them in their first FETCH cycle.
  task automatic do_reset();
    rst_n = 1'b0; ack = 1'b0; stall = 1'b0; pcsrc = 2'b00;
    step();
    rst_n = 1'b1;
    step();
  endtask

  // From a FETCH cycle: ack immediately, then leave ISSUE with the given pcsrc.
  task automatic issue_one(input logic [31:0] data, input logic [1:0] sel);
    ack = 1'b1; rdata = data;
    step();
    ack = 1'b0; stall = 1'b0; pcsrc = sel;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ack = 1'b1; rdata = 32'h1234_5678; stall = 1'b0; pcsrc = 2'b00;
    step();
    n_checks++;
    if (a_req !== 1'b0 || a_valid !== 1'b0 || a_err !== 1'b0) begin
      n_errors++; $display("FAIL rst_flags got req=%b valid=%b err=%b exp 0 0 0", a_req, a_valid, a_err);
    end
    n_checks++;
    if (a_pc !== 32'h100 || a_instr !== 32'h0) begin
      n_errors++; $display("FAIL rst_regs got pc=%h instr=%h exp 00000100 00000000", a_pc, a_instr);
    end
    rst_n = 1'b1;
    step();
    n_checks++;
    if (a_req !== 1'b1 || a_addr !== 32'h100 || a_instr !== 32'h0 || a_valid !== 1'b0) begin
      n_errors++; $display("FAIL rst_first_fetch got req=%b addr=%h instr=%h valid=%b exp 1 00000100 00000000 0",
                           a_req, a_addr, a_instr, a_valid);
    end
    step();
    ack = 1'b0;
    n_checks++;
    if (a_valid !== 1'b1 || a_req !== 1'b0 || a_instr !== 32'h1234_5678 || a_op !== 6'h04 || a_pc4 !== 32'h104) begin
      n_errors++; $display("FAIL rst_issue got valid=%b req=%b instr=%h op=%h pc4=%h exp 1 0 12345678 04 00000104",
                           a_valid, a_req, a_instr, a_op, a_pc4);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc;
    do_reset();
    exp_pc = 32'h100;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (a_req !== 1'b1 || a_addr !== exp_pc) begin
        n_errors++; $display("FAIL seq_addr[%0d] got req=%b addr=%h exp 1 %h", k, a_req, a_addr, exp_pc);
      end
      ack = 1'b0;
      step(); step();
      n_checks++;
      if (a_valid !== 1'b0 || a_req !== 1'b1) begin
        n_errors++; $display("FAIL seq_wait[%0d] got valid=%b req=%b exp 0 1", k, a_valid, a_req);
      end
      ack = 1'b1; rdata = 32'hA000_0000 + 32'(k);
      step();
      ack = 1'b0; pcsrc = 2'b00; stall = 1'b0;
      n_checks++;
      if (a_valid !== 1'b1 || a_instr !== 32'hA000_0000 + 32'(k) || a_pc !== exp_pc) begin
        n_errors++; $display("FAIL seq_issue[%0d] got valid=%b instr=%h pc=%h exp 1 %h %h",
                             k, a_valid, a_instr, a_pc, 32'hA000_0000 + 32'(k), exp_pc);
      end
      step();
      n_checks++;
      if (a_valid !== 1'b0) begin
        n_errors++; $display("FAIL seq_valid_drop[%0d] got %b exp 0", k, a_valid);
      end
      exp_pc = exp_pc + 32'd4;
    end
  endtask

  task automatic test_branch();
    // pc=0x10C: jump to 0x200 (index 0x80).
    issue_one(32'h0800_0080, 2'b10);
    n_checks++;
    if (a_addr !== 32'h200) begin
      n_errors++; $display("FAIL br_setup got %h exp 00000200", a_addr);
    end
    issue_one(32'h1000_FFFE, 2'b01);
    n_checks++;
    if (a_addr !== 32'h1FC) begin
      n_errors++; $display("FAIL br_neg got %h exp 000001fc", a_addr);
    end
    issue_one(32'h1000_0003, 2'b00);
    issue_one(32'h1000_0003, 2'b01);
    n_checks++;
    if (a_addr !== 32'h210) begin
      n_errors++; $display("FAIL br_pos got %h exp 00000210", a_addr);
    end
  endtask

  task automatic test_wrap();
    // 0x214 - 0x218 = 0xFFFF_FFFC.
    issue_one(32'h1000_FF7A, 2'b01);
    n_checks++;
    if (a_addr !== 32'hFFFF_FFFC) begin
      n_errors++; $display("FAIL wrap_setup got %h exp fffffffc", a_addr);
    end
    ack = 1'b1; rdata = 32'h0000_0000;
    step();
    ack = 1'b0; pcsrc = 2'b00;
    n_checks++;
    if (a_pc4 !== 32'h0) begin
      n_errors++; $display("FAIL wrap_pc4 got %h exp 00000000", a_pc4);
    end
    step();
    n_checks++;
    if (a_addr !== 32'h0 || a_req !== 1'b1) begin
      n_errors++; $display("FAIL wrap_addr got addr=%h req=%b exp 00000000 1", a_addr, a_req);
    end
  endtask

  task automatic test_jump();
    do_reset();
    ack = 1'b1; rdata = 32'h0800_0010;
    step();
    ack = 1'b0; pcsrc = 2'b10;
    n_checks++;
    if (b_pc4 !== 32'h3000_0000) begin
      n_errors++; $display("FAIL jmp_hi_pc4 got %h exp 30000000", b_pc4);
    end
    step();
    n_checks++;
    if (b_addr !== 32'h3000_0040 || a_addr !== 32'h40) begin
      n_errors++; $display("FAIL jmp_cross got hi=%h lo=%h exp 30000040 00000040", b_addr, a_addr);
    end
    issue_one(32'h0800_0010, 2'b10);
    n_checks++;
    if (b_addr !== 32'h3000_0040 || a_addr !== 32'h40) begin
      n_errors++; $display("FAIL jmp_same got hi=%h lo=%h exp 30000040 00000040", b_addr, a_addr);
    end
  endtask

  task automatic test_stall();
    logic [1:0] sel_seq [4];
    sel_seq = '{2'b01, 2'b10, 2'b11, 2'b01};
    // Lower instance sits at pc=0x40.
    ack = 1'b1; rdata = 32'hAABB_CCDD;
    step();
    stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      pcsrc = sel_seq[k];
      ack = 1'b1; rdata = 32'h5555_0000 + 32'(k);
      step();
      n_checks++;
      if (a_valid !== 1'b1 || a_req !== 1'b0 || a_instr !== 32'hAABB_CCDD || a_pc !== 32'h40) begin
        n_errors++; $display("FAIL stall_hold[%0d] got valid=%b req=%b instr=%h pc=%h exp 1 0 aabbccdd 00000040",
                             k, a_valid, a_req, a_instr, a_pc);
      end
    end
    ack = 1'b0; stall = 1'b0; pcsrc = 2'b00;
    step();
    n_checks++;
    if (a_addr !== 32'h44 || a_req !== 1'b1) begin
      n_errors++; $display("FAIL stall_release got addr=%h req=%b exp 00000044 1", a_addr, a_req);
    end
  endtask

  task automatic test_timeout();
    ack = 1'b0;
    for (int k = 0; k < 15; k++) step();
    n_checks++;
    if (a_err !== 1'b0 || a_req !== 1'b1) begin
      n_errors++; $display("FAIL to_early got err=%b req=%b exp 0 1", a_err, a_req);
    end
    step();
    n_checks++;
    if (a_err !== 1'b1 || a_req !== 1'b0 || a_valid !== 1'b0) begin
      n_errors++; $display("FAIL to_trip got err=%b req=%b valid=%b exp 1 0 0", a_err, a_req, a_valid);
    end
    ack = 1'b1;
    for (int k = 0; k < 3; k++) step();
    n_checks++;
    if (a_err !== 1'b1 || a_req !== 1'b0 || a_valid !== 1'b0) begin
      n_errors++; $display("FAIL to_sticky got err=%b req=%b valid=%b exp 1 0 0", a_err, a_req, a_valid);
    end
    ack = 1'b0;
  endtask

  task automatic test_reset_midfetch();
    do_reset();
    n_checks++;
    if (a_err !== 1'b0 || a_addr !== 32'h100) begin
      n_errors++; $display("FAIL err_clear got err=%b addr=%h exp 0 00000100", a_err, a_addr);
    end
    issue_one(32'h0, 2'b00);
    ack = 1'b0;
    step(); step(); step();
    rst_n = 1'b0;
    step();
    n_checks++;
    if (a_pc !== 32'h100 || a_req !== 1'b0) begin
      n_errors++; $display("FAIL mid_rst got pc=%h req=%b exp 00000100 0", a_pc, a_req);
    end
    rst_n = 1'b1; ack = 1'b1; rdata = 32'hBAD0_BAD0;
    step();
    n_checks++;
    if (a_req !== 1'b1 || a_addr !== 32'h100 || a_instr !== 32'h0) begin
      n_errors++; $display("FAIL mid_late_ack got req=%b addr=%h instr=%h exp 1 00000100 00000000",
                           a_req, a_addr, a_instr);
    end
    rdata = 32'h2000_0001;
    step();
    ack = 1'b0;
    n_checks++;
    if (a_valid !== 1'b1 || a_instr !== 32'h2000_0001 || a_op !== 6'h08) begin
      n_errors++; $display("FAIL mid_refetch got valid=%b instr=%h op=%h exp 1 20000001 08",
                           a_valid, a_instr, a_op);
    end
  endtask

  initial begin
    rst_n = 1'b0; ack = 1'b0; rdata = 32'h0; pcsrc = 2'b00; stall = 1'b0;
    step();
    test_reset();
    test_sequential();
    test_branch();
    test_wrap();
    test_jump();
    test_stall();
    test_timeout();
    test_reset_midfetch();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Instruction fetch sequencer that drives the opcode and instruction word consumed by the control unit, and consumes that unit's PCsrc decision to advance the program counter. It owns the PC register and the request/acknowledge handshake to instruction memory. It presents one instruction at a time and holds it while the datapath is stalled. It computes sequential, branch and jump targets locally.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
TIMEOUT, 16, max cycles in FETCH without imem_ack before error (range 1..255)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-low reset
imem_req  output  1  instruction memory read request
imem_addr  output  32  word-aligned fetch address (equals pc)
imem_ack  input  1  memory data valid this cycle
imem_rdata  input  32  instruction word, sampled when imem_req && imem_ack
pcsrc  input  2  next-PC select from control unit: 00 seq, 01 branch, 10 jump, 11 reserved
stall  input  1  hold current instruction; no PC update
instr  output  32  registered current instruction
opcode  output  6  instr[31:26]
pc  output  32  address of current instruction
pc_plus4  output  32  pc + 4
instr_valid  output  1  instr/opcode valid for decode
fetch_err  output  1  sticky timeout flag

Behaviour:
- Reset (reset==0 at a rising edge): state=FLUSH, pc=RESET_PC, instr=0, imem_req=0, instr_valid=0, fetch_err=0, timeout counter=0. Reset overrides every other input in that cycle, including mid-fetch and ERR.
- States: FLUSH, FETCH, ISSUE, ERR. All outputs are registered or decoded from state; opcode and pc_plus4 are derived from registered values.
- FLUSH: imem_req=0 for exactly one cycle; any imem_ack is ignored. -> FETCH.
- FETCH: imem_req=1, imem_addr=pc, held stable until accepted. If imem_ack: instr<=imem_rdata, counter cleared, -> ISSUE. If no ack: counter increments. When counter reaches TIMEOUT: fetch_err<=1 and -> ERR.
- Minimum fetch latency: 1 cycle, with ack in the first FETCH cycle. instr_valid rises on the following edge.
- ISSUE: instr_valid=1, imem_req=0. If stall=1: hold state, pc and instr; pcsrc is ignored. If stall=0, pc is updated at the edge per pcsrc sampled in that cycle, then -> FETCH:
  - 00: pc+4
  - 01: pc+4 + (sign_extend(instr[15:0]) << 2)
  - 10: {pc_plus4[31:28], instr[25:0], 2'b00}
  - 11: pc+4 (reserved, treated as sequential)
- instr_valid falls in the FETCH cycle. Throughput: 1 instruction per 2 cycles minimum.
- Arithmetic: all PC sums are 32-bit modulo 2^32; wrap at 32'hFFFF_FFFC + 4 gives 0. Negative offsets are allowed. imem_addr[1:0] is always 00 unless RESET_PC is misaligned (RESET_PC must be misaligned never; the block does not check it).
- imem_ack while imem_req=0 is ignored in every state.
- ERR: imem_req=0, instr_valid=0, fetch_err=1. The block exits ERR only on reset.
- Simultaneous stall=1 and a pcsrc change in ISSUE: stall wins; the pcsrc value is used on the first non-stalled cycle.

Test Plan:
- Reset with RESET_PC=0x100, then release; memory acks in the same cycle -> one FLUSH cycle with req=0, then imem_addr=0x100; instr_valid=1 two cycles after release.
- Sequential: pcsrc=00, stall=0, 3 instructions, ack with 2-cycle delay -> addresses 0x100, 0x104, 0x108; each instr presented for 1 cycle.
- Branch: at pc=0x200, instr=0x1000FFFE (beq, imm=-2), pcsrc=01 -> next imem_addr=0x1FC. With imm=0x0003 -> 0x210.
- Jump: at pc=0x3000_0040, instr=0x0800_0010, pcsrc=10 -> next imem_addr=0x3000_0040.
- Stall: stall=1 for 4 cycles in ISSUE while pcsrc toggles -> instr, pc and instr_valid=1 held, no req. Releasing with pcsrc=00 -> pc+4.
- Timeout and reset: withhold ack for 16 cycles -> fetch_err=1, req=0, stays in ERR. Then test reset mid-fetch with a late ack in the FLUSH cycle -> ack is ignored and the refetch is from RESET_PC. Also wrap: pc=0xFFFF_FFFC with pcsrc=00 -> next imem_addr=0x0.
